// File: rtl/reg_file32_if.sv
`default_nettype none
//==============================================================================
// Module      : reg_file32_if
// Description : Bus bundle for the reg_file32 register file. It carries the
//               write port, the two operand read ports, the debug read port
//               and the write counter. The CPU datapath uses the master side
//               and the register file uses the slave side.
// Revision    : 1.0 - initial release
//==============================================================================
interface reg_file32_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] raddr1;
    logic [ADDR_WIDTH-1:0] raddr2;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_data;
    logic [CNT_WIDTH-1:0]  wr_count;

    // Datapath side: drives indices and write data, consumes read data
    modport master (
        output we, waddr, wdata, raddr1, raddr2, dbg_addr,
        input  rdata1, rdata2, dbg_data, wr_count
    );

    // Register-file side
    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, dbg_addr,
        output rdata1, rdata2, dbg_data, wr_count
    );
endinterface
`default_nettype wire

// File: rtl/reg_file32.sv
`default_nettype none
//==============================================================================
// Module      : reg_file32
// Description : MIPS-style general-purpose register file. It has two
//               combinational read ports for the ALU operands, one synchronous
//               write port, a debug read port and a saturating counter of
//               committed writes. Register 0 always reads as zero.
//               Optional feature macro: REGFILE_WR_BYPASS_EN. When it is
//               defined, write data is forwarded to rdata1/rdata2 in the cycle
//               of the write. dbg_data is never forwarded.
// Revision    : 1.0 - initial release
//==============================================================================
module reg_file32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    reg_file32_if.slave  bus
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    // A write only takes effect when it targets a real (non-zero) register
    logic                  w_commit;
    logic [DATA_WIDTH-1:0] w_regs [c_DEPTH];
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;
    logic [DATA_WIDTH-1:0] w_dbg;
    logic [CNT_WIDTH-1:0]  r_wr_count;

    assign w_commit = bus.we && (bus.waddr != '0);

    // Index 0 has no storage and always reads as zero
    assign w_regs[0] = '0;

    // One storage word per non-zero index, cleared asynchronously
    for (genvar gi = 1; gi < c_DEPTH; gi++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_q;

        // Capture write data when this index is the committed write target
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_commit && (bus.waddr == ADDR_WIDTH'(gi))) begin
                r_q <= bus.wdata;
            end
        end

        assign w_regs[gi] = r_q;
    end

    // Count committed writes and hold at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_count <= '0;
        end else if (w_commit && (r_wr_count != {CNT_WIDTH{1'b1}})) begin
            r_wr_count <= r_wr_count + CNT_WIDTH'(1);
        end
    end

    // Operand read ports, with optional same-cycle forwarding of write data
    always_comb begin
        w_rd1 = w_regs[bus.raddr1];
        w_rd2 = w_regs[bus.raddr2];
`ifdef REGFILE_WR_BYPASS_EN
        // w_commit excludes index 0, so register 0 is never forwarded
        if (w_commit && (bus.raddr1 == bus.waddr)) begin
            w_rd1 = bus.wdata;
        end
        if (w_commit && (bus.raddr2 == bus.waddr)) begin
            w_rd2 = bus.wdata;
        end
`endif
    end

    // The debug port always shows stored state and is never forwarded
    always_comb begin
        w_dbg = w_regs[bus.dbg_addr];
    end

    // Force reads to zero while reset is held. This also blocks forwarded
    // write data, which would otherwise appear during reset.
    assign bus.rdata1   = rst_n ? w_rd1 : '0;
    assign bus.rdata2   = rst_n ? w_rd2 : '0;
    assign bus.dbg_data = rst_n ? w_dbg : '0;
    assign bus.wr_count = r_wr_count;

endmodule
`default_nettype wire
